// File: rtl/pp_reduce_seq.sv
// pp_reduce_seq: sequential partial-product reducer for the Wallace multiplier.
// It accepts a bank of N rows, each 2N bits wide, in a single beat. It folds
// RPC rows per cycle into a carry-save sum/carry pair, then resolves that pair
// with one carry-propagate add and offers the 2N-bit product on valid/ready.
module pp_reduce_seq #(
    parameter int N   = 32,
    parameter int RPC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*2*N-1:0]   pp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     product,
    output logic               busy
);
    localparam int W    = 2 * N;
    localparam int PPW  = N * W;
    localparam int IDXW = $clog2(N + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - RPC);
    localparam logic [IDXW-1:0] STEP     = IDXW'(RPC);

    // Refuse to elaborate unless the row groups tile the bank exactly.
    if ((N % RPC) != 0) begin : g_rpc_check
        $error("pp_reduce_seq: N must be a multiple of RPC");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REDUCE  = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // One 3:2 compressor. Result is {carry << 1, sum}; the carry bit that
    // leaves position W-1 is dropped because the result is taken mod 2^W.
    function automatic logic [2*W-1:0] csa32(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        logic [W-1:0] s;
        logic [W-1:0] maj;
        s   = a ^ b ^ c;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[W-2:0], 1'b0, s};
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PPW-1:0]    r_rows;
    logic [W-1:0]      r_sum;
    logic [W-1:0]      r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [W-1:0]      r_product;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;
    logic              w_accept;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;
    logic              w_busy_nxt;
    logic [W-1:0]      w_acc_sum;
    logic [W-1:0]      w_acc_carry;
    logic [W-1:0]      w_row;

    assign w_accept = in_valid & r_in_ready;

    // Carry-save fold of the current sum/carry with the next RPC rows. Rows
    // are consumed from the bottom of the buffer, which shifts down each cycle.
    always_comb begin
        w_acc_sum   = r_sum;
        w_acc_carry = r_carry;
        w_row       = '0;
        for (int j = 0; j < RPC; j++) begin
            w_row = r_rows[j*W +: W];
            {w_acc_carry, w_acc_sum} = csa32(w_acc_sum, w_acc_carry, w_row);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_REDUCE;
                else          w_state_nxt = S_IDLE;
            end
            S_REDUCE: begin
                if (r_idx == LAST_IDX) w_state_nxt = S_RESOLVE;
                else                   w_state_nxt = S_REDUCE;
            end
            S_RESOLVE: w_state_nxt = S_DONE;
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
                else           w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, so the handshake flags are registered.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b1;
        case (w_state_nxt)
            S_IDLE: begin
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
            end
            S_REDUCE:  w_busy_nxt = 1'b1;
            S_RESOLVE: w_busy_nxt = 1'b1;
            S_DONE:    w_out_valid_nxt = 1'b1;
            default: begin
                w_in_ready_nxt  = 1'b0;
                w_out_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b1;
            end
        endcase
    end

    // Handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Datapath: capture the bank, fold groups of rows, and resolve the final add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows    <= '0;
            r_sum     <= '0;
            r_carry   <= '0;
            r_idx     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rows  <= pp;
                        r_sum   <= '0;
                        r_carry <= '0;
                        r_idx   <= '0;
                    end
                end
                S_REDUCE: begin
                    r_sum   <= w_acc_sum;
                    r_carry <= w_acc_carry;
                    r_idx   <= r_idx + STEP;
                    r_rows  <= r_rows >> (RPC * W);
                end
                S_RESOLVE: r_product <= r_sum + r_carry;
                S_DONE:    r_product <= r_product;
                default:   r_product <= r_product;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_product;

endmodule
